// File: rtl/pipe_ctrl_pkg.sv
// Shared types and pipeline-register indices for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: per-register enable/flush strobes for IF/ID..MEM/WB and PC.
// Optional perf counters (stall_cnt/flush_cnt) are built only when PIPE_PERF_CNT_EN is defined.
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES      = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_use,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              halt_req,
    output logic              pc_en,
    output logic [STAGES-1:0] en,
    output logic [STAGES-1:0] flush,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;
    localparam int DR_W = $clog2(STAGES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(STAGES - 2);

    state_t            state_q, state_d;
    logic              fault_q, fault_d;
    logic [TO_W-1:0]   timeout_q;
    logic [DR_W-1:0]   drain_q;
    logic              to_inc_s, to_clr_s, dr_inc_s, dr_clr_s;
    logic              stall_inc_s, flush_inc_s;
    logic              pc_en_s, halted_s;
    logic [STAGES-1:0] en_s, flush_s;

    // State and sticky fault registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= START;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Next state and strobes; mem_busy freezes RUN/DRAIN and runs the timeout
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        pc_en_s     = 1'b0;
        en_s        = '0;
        flush_s     = '0;
        halted_s    = 1'b0;
        to_inc_s    = 1'b0;
        to_clr_s    = !mem_busy;
        dr_inc_s    = 1'b0;
        dr_clr_s    = (state_q != DRAIN);
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_q)
            START: begin
                en_s    = '1;
                flush_s = '1;
                state_d = RUN;
            end
            RUN: begin
                if (mem_busy) begin
                    to_inc_s = 1'b1;
                    if (timeout_q == TO_LAST) begin
                        state_d = HALTED;
                        fault_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (branch_taken) begin
                    pc_en_s        = 1'b1;
                    en_s           = '1;
                    flush_s[IFID]  = 1'b1;
                    flush_s[IDEX]  = 1'b1;
                    flush_s[EXMEM] = 1'b1;
                    flush_inc_s    = 1'b1;
                end else if (load_use) begin
                    en_s          = '1;
                    en_s[IFID]    = 1'b0;
                    flush_s[IDEX] = 1'b1;
                    stall_inc_s   = 1'b1;
                end else if (halt_req) begin
                    en_s          = '1;
                    flush_s[IFID] = 1'b1;
                    state_d       = DRAIN;
                end else begin
                    pc_en_s = 1'b1;
                    en_s    = '1;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    to_inc_s = 1'b1;
                    if (timeout_q == TO_LAST) begin
                        state_d = HALTED;
                        fault_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    en_s          = '1;
                    flush_s[IFID] = 1'b1;
                    dr_inc_s      = 1'b1;
                    if (drain_q == DR_LAST) begin
                        state_d = HALTED;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            HALTED: begin
                halted_s = 1'b1;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // A low reset overrides the strobes combinationally, before the edge lands
    always_comb begin
        if (!reset) begin
            pc_en  = 1'b0;
            en     = '0;
            flush  = '1;
            halted = 1'b0;
            fault  = 1'b0;
        end else begin
            pc_en  = pc_en_s;
            en     = en_s;
            flush  = flush_s;
            halted = halted_s;
            fault  = fault_q;
        end
    end

    sat_counter #(.W(TO_W)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (to_clr_s),
        .inc   (to_inc_s),
        .q     (timeout_q)
    );

    sat_counter #(.W(DR_W)) u_drain (
        .clk   (clk),
        .reset (reset),
        .clr   (dr_clr_s),
        .inc   (dr_inc_s),
        .q     (drain_q)
    );

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (stall_inc_s),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (flush_inc_s),
        .q     (flush_cnt)
    );
`else
    logic perf_unused_s;
    assign perf_unused_s = stall_inc_s ^ flush_inc_s;
    assign stall_cnt     = '0;
    assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencing rules.
module tb_pipe_seq_ctrl;

    localparam int STAGES      = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic              clk;
    logic              reset, load_use, branch_taken, mem_busy, halt_req;
    logic              pc_en, halted, fault;
    logic [STAGES-1:0] en, flush;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_seq_ctrl #(.STAGES(STAGES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .pc_en        (pc_en),
        .en           (en),
        .flush        (flush),
        .halted       (halted),
        .fault        (fault),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what has happened so far, in plain terms
    bit          m_valid      = 1'b0;
    bit          m_just_reset = 1'b0;  // first cycle after reset release
    bit          m_halted     = 1'b0;
    bit          m_fault      = 1'b0;
    int          m_drain_left = 0;     // drain cycles still owed
    int          m_busy_run   = 0;     // consecutive busy cycles while active
    longint      m_stalls     = 0;
    longint      m_flushes    = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint exp_stall();
`ifdef PIPE_PERF_CNT_EN
        return m_stalls;
`else
        return 64'd0;
`endif
    endfunction

    function automatic longint exp_flush();
`ifdef PIPE_PERF_CNT_EN
        return m_flushes;
`else
        return 64'd0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_valid      <= 1'b1;
            m_just_reset <= 1'b1;
            m_halted     <= 1'b0;
            m_fault      <= 1'b0;
            m_drain_left <= 0;
            m_busy_run   <= 0;
            m_stalls     <= 0;
            m_flushes    <= 0;
        end else if (m_valid) begin
            if (!mem_busy) m_busy_run <= 0;
            if (m_halted) begin
                // frozen until reset
            end else if (m_just_reset) begin
                m_just_reset <= 1'b0;
            end else if (mem_busy) begin
                m_busy_run <= m_busy_run + 1;
                if (m_busy_run + 1 == MEM_TIMEOUT) begin
                    m_halted <= 1'b1;
                    m_fault  <= 1'b1;
                end
            end else if (m_drain_left > 0) begin
                m_drain_left <= m_drain_left - 1;
                if (m_drain_left == 1) m_halted <= 1'b1;
            end else if (branch_taken) begin
                m_flushes <= m_flushes + 1;
            end else if (load_use) begin
                m_stalls <= m_stalls + 1;
            end else if (halt_req) begin
                m_drain_left <= STAGES - 1;
            end
        end
    end

    // Compare process: expected outputs from model state plus current inputs
    always @(negedge clk) begin
        bit e_pc, e_h, e_f;
        logic [3:0] e_en, e_fl;
        if (m_valid) begin
            e_pc = 1'b0; e_en = 4'h0; e_fl = 4'h0; e_h = 1'b0; e_f = 1'b0;
            if (!reset) begin
                e_fl = 4'hF;
            end else if (m_halted) begin
                e_h = 1'b1; e_f = m_fault;
            end else if (m_just_reset) begin
                e_en = 4'hF; e_fl = 4'hF;
            end else if (mem_busy) begin
                e_en = 4'h0;
            end else if (m_drain_left > 0) begin
                e_en = 4'hF; e_fl = 4'h1;
            end else if (branch_taken) begin
                e_pc = 1'b1; e_en = 4'hF; e_fl = 4'h7;
            end else if (load_use) begin
                e_en = 4'hE; e_fl = 4'h2;
            end else if (halt_req) begin
                e_en = 4'hF; e_fl = 4'h1;
            end else begin
                e_pc = 1'b1; e_en = 4'hF;
            end
            chk("model_pc_en",  pc_en,  e_pc);
            chk("model_en",     en,     e_en);
            chk("model_flush",  flush,  e_fl);
            chk("model_halted", halted, e_h);
            chk("model_fault",  fault,  e_f);
            if (^stall_cnt === 1'bx || ^flush_cnt === 1'bx) begin
                chk("model_cnt_known", 64'd1, 64'd0);
            end else begin
                chk("model_stall_cnt", stall_cnt, exp_stall());
                chk("model_flush_cnt", flush_cnt, exp_flush());
            end
        end
    end

    // Drive one cycle's inputs just after the edge; returns shortly before negedge
    task automatic cyc(input logic r, input logic lu, input logic br,
                       input logic mb, input logic hr);
        @(posedge clk);
        #1;
        reset = r; load_use = lu; branch_taken = br; mem_busy = mb; halt_req = hr;
        #3;
    endtask

    initial begin
        int burst;
        int hcnt;
        logic r, lu, br, mb, hr;
        reset = 1'b0; load_use = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;

        // T1: reset for three cycles, then START, then RUN
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1_rst_flush", flush, 64'hF);
            chk("t1_rst_en", en, 64'h0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_start_flush", flush, 64'hF);
        chk("t1_start_pc_en", pc_en, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_run_pc_en", pc_en, 64'd1);
        chk("t1_run_en", en, 64'hF);

        // T2: load-use stall
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_pc_en", pc_en, 64'd0);
        chk("t2_en", en, 64'hE);
        chk("t2_flush", flush, 64'h2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 64'd1);
`else
        chk("t2_stall_cnt", stall_cnt, 64'd0);
`endif

        // T3: branch beats load-use
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_flush", flush, 64'h7);
        chk("t3_pc_en", pc_en, 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("t3_stall_cnt", stall_cnt, 64'd1);
        chk("t3_flush_cnt", flush_cnt, 64'd1);
`else
        chk("t3_flush_cnt", flush_cnt, 64'd0);
`endif

        // T4: 15 busy cycles survive, 16 trip the timeout
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("t4_frozen_en", en, 64'h0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_no_fault", fault, 64'd0);
        chk("t4_not_halted", halted, 64'd0);
        for (int i = 0; i < MEM_TIMEOUT; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_halted", halted, 64'd1);
        chk("t4_fault", fault, 64'd1);
        chk("t4_halt_pc_en", pc_en, 64'd0);

        // T5: halt request drains three registers then freezes
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_fault_cleared", fault, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_req_flush", flush, 64'h1);
        chk("t5_req_pc_en", pc_en, 64'd0);
        for (int i = 0; i < STAGES - 1; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t5_drain_flush", flush, 64'h1);
            chk("t5_drain_en", en, 64'hF);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_halted", halted, 64'd1);
        chk("t5_halted_en", en, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_stays_halted", halted, 64'd1);

        // T6: reset in the middle of a drain
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_en", en, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_start_flush", flush, 64'hF);
        chk("t6_start_en", en, 64'hF);
        chk("t6_halted", halted, 64'd0);
        chk("t6_stall_cnt", stall_cnt, 64'd0);
        chk("t6_flush_cnt", flush_cnt, 64'd0);

        // Randomized traffic, checked by the compare process
        burst = 0;
        hcnt  = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 299) != 0);
            hcnt = m_halted ? hcnt + 1 : 0;
            if (hcnt > 4) r = 1'b0;
            if (burst > 0) begin
                burst--;
                mb = 1'b1;
            end else begin
                if ($urandom_range(0, 99) < 2) burst = $urandom_range(12, 20);
                mb = ($urandom_range(0, 3) == 0);
            end
            lu = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 4) == 0);
            hr = ($urandom_range(0, 59) == 0);
            cyc(r, lu, br, mb, hr);
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
